// File: rtl/wave_measure_pkg.sv
// Shared types and widths for the waveform period/amplitude measurement block.
package wave_measure_pkg;

    localparam int CNT_W = 20;
    localparam int SMP_W = 8;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } meas_state_t;

    function automatic logic [SMP_W-1:0] smp_max(input logic [SMP_W-1:0] a,
                                                 input logic [SMP_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [SMP_W-1:0] smp_min(input logic [SMP_W-1:0] a,
                                                 input logic [SMP_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/wave_edge_detect.sv
// Hysteresis rising-crossing detector: arms at or below THRESH_LO, fires at or above THRESH_HI.
module wave_edge_detect
    import wave_measure_pkg::*;
#(
    parameter logic [SMP_W-1:0] THRESH_HI = 8'd144,
    parameter logic [SMP_W-1:0] THRESH_LO = 8'd112
) (
    input  logic             CLK,
    input  logic             Rstn,
    input  logic             Sample_En,
    input  logic [SMP_W-1:0] Wave_Data,
    input  logic             Disarm,
    output logic             Rise_Event
);

    logic armed;

    assign Rise_Event = armed && Sample_En && (Wave_Data >= THRESH_HI);

    // Disarm wins so a timeout sample below THRESH_LO cannot leave the detector armed.
    always_ff @(posedge CLK or negedge Rstn) begin
        if (!Rstn) begin
            armed <= 1'b0;
        end else if (Disarm) begin
            armed <= 1'b0;
        end else if (Sample_En) begin
            if (Rise_Event)
                armed <= 1'b0;
            else if (Wave_Data <= THRESH_LO)
                armed <= 1'b1;
        end
    end

endmodule

// File: rtl/wave_measure_module.sv
// Measures period (in accepted samples) and min/max/peak-to-peak between rising crossings.
//   state      | meaning
//   ST_IDLE    | no period reference yet (after reset or loss of signal)
//   ST_MEASURE | counting accepted samples since the last rising event
module wave_measure_module
    import wave_measure_pkg::*;
#(
    parameter logic [SMP_W-1:0] THRESH_HI = 8'd144,
    parameter logic [SMP_W-1:0] THRESH_LO = 8'd112,
    parameter logic [CNT_W-1:0] TIMEOUT   = 20'd1000000
) (
    input  logic             CLK,
    input  logic             Rstn,
    input  logic             Sample_En,
    input  logic [SMP_W-1:0] Wave_Data,
    output logic [CNT_W-1:0] Period_Out,
    output logic [SMP_W-1:0] Max_Out,
    output logic [SMP_W-1:0] Min_Out,
    output logic [SMP_W-1:0] Vpp_Out,
    output logic             Meas_Valid,
    output logic             No_Signal
);

    localparam logic [CNT_W-1:0] TMO_LOAD = TIMEOUT - 20'd1;

    meas_state_t      state;
    logic [CNT_W-1:0] smp_cnt;
    logic [CNT_W-1:0] tmo_left;
    logic [SMP_W-1:0] run_max;
    logic [SMP_W-1:0] run_min;
    logic             rise_event;
    logic             timeout_hit;

    wave_edge_detect #(
        .THRESH_HI (THRESH_HI),
        .THRESH_LO (THRESH_LO)
    ) u_edge (
        .CLK        (CLK),
        .Rstn       (Rstn),
        .Sample_En  (Sample_En),
        .Wave_Data  (Wave_Data),
        .Disarm     (timeout_hit),
        .Rise_Event (rise_event)
    );

    // Loss-of-signal timer runs down alongside smp_cnt; reaching zero means smp_cnt == TIMEOUT-1.
    assign timeout_hit = Sample_En && (state == ST_MEASURE) && !rise_event && (tmo_left == '0);

    always_ff @(posedge CLK or negedge Rstn) begin
        if (!Rstn) begin
            state      <= ST_IDLE;
            smp_cnt    <= '0;
            tmo_left   <= '0;
            run_max    <= '0;
            run_min    <= '0;
            Period_Out <= '0;
            Max_Out    <= '0;
            Min_Out    <= '0;
            Vpp_Out    <= '0;
            Meas_Valid <= 1'b0;
            No_Signal  <= 1'b0;
        end else begin
            Meas_Valid <= 1'b0;
            if (Sample_En) begin
                case (state)
                    ST_IDLE: begin
                        if (rise_event) begin
                            state    <= ST_MEASURE;
                            smp_cnt  <= '0;
                            tmo_left <= TMO_LOAD;
                            run_max  <= Wave_Data;
                            run_min  <= Wave_Data;
                        end
                    end
                    ST_MEASURE: begin
                        if (rise_event) begin
                            Period_Out <= smp_cnt + 20'd1;
                            Max_Out    <= run_max;
                            Min_Out    <= run_min;
                            Vpp_Out    <= run_max - run_min;
                            Meas_Valid <= 1'b1;
                            No_Signal  <= 1'b0;
                            smp_cnt    <= '0;
                            tmo_left   <= TMO_LOAD;
                            run_max    <= Wave_Data;
                            run_min    <= Wave_Data;
                        end else if (timeout_hit) begin
                            No_Signal <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            smp_cnt  <= smp_cnt + 20'd1;
                            tmo_left <= tmo_left - 20'd1;
                            run_max  <= smp_max(run_max, Wave_Data);
                            run_min  <= smp_min(run_min, Wave_Data);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wave_measure_module.sv
// Randomized and directed bench for wave_measure_module against a sample-history reference model.
module tb_wave_measure_module;

    localparam logic [7:0] HI  = 8'd144;
    localparam logic [7:0] LO  = 8'd112;
    localparam int         TMO = 50;

    logic        CLK = 1'b0;
    logic        Rstn = 1'b1;
    logic        Sample_En = 1'b0;
    logic [7:0]  Wave_Data = 8'd0;
    logic [19:0] Period_Out;
    logic [7:0]  Max_Out, Min_Out, Vpp_Out;
    logic        Meas_Valid, No_Signal;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    // Reference model state: samples accepted since the last rising event.
    bit          m_armed, m_ref;
    logic [7:0]  hist[$];
    logic [19:0] e_period;
    logic [7:0]  e_max, e_min, e_vpp;
    logic        e_valid, e_nosig;

    wave_measure_module #(
        .THRESH_HI (HI),
        .THRESH_LO (LO),
        .TIMEOUT   (20'd50)
    ) dut (
        .CLK        (CLK),
        .Rstn       (Rstn),
        .Sample_En  (Sample_En),
        .Wave_Data  (Wave_Data),
        .Period_Out (Period_Out),
        .Max_Out    (Max_Out),
        .Min_Out    (Min_Out),
        .Vpp_Out    (Vpp_Out),
        .Meas_Valid (Meas_Valid),
        .No_Signal  (No_Signal)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_armed = 0; m_ref = 0; hist.delete();
        e_period = '0; e_max = '0; e_min = '0; e_vpp = '0;
        e_valid = 1'b0; e_nosig = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic [7:0] s);
        bit ev;
        logic [7:0] mx, mn;
        e_valid = 1'b0;
        if (!en) return;
        ev = m_armed && (s >= HI);
        if (ev) m_armed = 0;
        else if (s <= LO) m_armed = 1;
        if (ev) begin
            if (m_ref) begin
                mx = 8'd0; mn = 8'd255;
                foreach (hist[i]) begin
                    if (hist[i] > mx) mx = hist[i];
                    if (hist[i] < mn) mn = hist[i];
                end
                e_period = 20'(hist.size());
                e_max = mx; e_min = mn; e_vpp = mx - mn;
                e_valid = 1'b1; e_nosig = 1'b0;
            end
            hist.delete();
            hist.push_back(s);
            m_ref = 1;
        end else if (m_ref) begin
            if (hist.size() == TMO) begin
                e_nosig = 1'b1; m_ref = 0; m_armed = 0; hist.delete();
            end else begin
                hist.push_back(s);
            end
        end
    endtask

    // Drive one clock's worth of input, then land 1 time unit after the edge.
    task automatic cycle(input logic en, input logic [7:0] d);
        Sample_En = en; Wave_Data = d;
        @(posedge CLK);
        model_step(en, d);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        Rstn = 1'b0; Sample_En = 1'b0;
        #3;
        Rstn = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        #1 Rstn = 1'b0;
        #2;
        vectors++;
        if ({Period_Out, Max_Out, Min_Out, Vpp_Out, Meas_Valid, No_Signal} !== 46'd0) begin
            errors++;
            $display("FAIL reset_async: got P=%0d max=%0d min=%0d vpp=%0d v=%b ns=%b, want all 0",
                     Period_Out, Max_Out, Min_Out, Vpp_Out, Meas_Valid, No_Signal);
        end
        Sample_En = 1'b1; Wave_Data = 8'd255;
        repeat (3) @(posedge CLK);
        #1;
        vectors++;
        if ({Period_Out, Max_Out, Min_Out, Vpp_Out, Meas_Valid, No_Signal} !== 46'd0) begin
            errors++;
            $display("FAIL reset_hold: got P=%0d max=%0d v=%b ns=%b, want all 0",
                     Period_Out, Max_Out, Meas_Valid, No_Signal);
        end
        do_reset();
    endtask

    task automatic test_square();
        int nvalid = 0;
        int last = -1;
        do_reset();
        for (int p = 0; p < 6; p++) begin
            for (int k = 0; k < 20; k++) begin
                cycle(1'b1, (k < 10) ? 8'd255 : 8'd0);
                vectors++;
                if (Meas_Valid !== e_valid) begin
                    errors++; $display("FAIL square_valid: got %b want %b", Meas_Valid, e_valid);
                end
                vectors++;
                if ({Period_Out, Max_Out, Min_Out, Vpp_Out, No_Signal} !== {e_period, e_max, e_min, e_vpp, e_nosig}) begin
                    errors++;
                    $display("FAIL square_out: got P=%0d max=%0d min=%0d vpp=%0d ns=%b want P=%0d max=%0d min=%0d vpp=%0d ns=%b",
                             Period_Out, Max_Out, Min_Out, Vpp_Out, No_Signal, e_period, e_max, e_min, e_vpp, e_nosig);
                end
                if (Meas_Valid === 1'b1) begin
                    if (last >= 0) begin
                        vectors++;
                        if (cyc - last != 20) begin
                            errors++; $display("FAIL square_spacing: got %0d cycles want 20", cyc - last);
                        end
                    end
                    last = cyc;
                    nvalid++;
                end
            end
        end
        vectors++;
        if (nvalid != 4) begin
            errors++; $display("FAIL square_count: got %0d pulses want 4", nvalid);
        end
    endtask

    task automatic test_sawtooth();
        int nvalid = 0;
        do_reset();
        for (int p = 0; p < 5; p++) begin
            for (int k = 0; k < 16; k++) begin
                cycle(1'b1, 8'(k * 16));
                vectors++;
                if (Meas_Valid !== e_valid) begin
                    errors++; $display("FAIL saw_valid: got %b want %b", Meas_Valid, e_valid);
                end
                vectors++;
                if ({Period_Out, Max_Out, Min_Out, Vpp_Out, No_Signal} !== {e_period, e_max, e_min, e_vpp, e_nosig}) begin
                    errors++;
                    $display("FAIL saw_out: got P=%0d max=%0d min=%0d vpp=%0d want P=%0d max=%0d min=%0d vpp=%0d",
                             Period_Out, Max_Out, Min_Out, Vpp_Out, e_period, e_max, e_min, e_vpp);
                end
                if (Meas_Valid === 1'b1) nvalid++;
            end
        end
        vectors++;
        if (nvalid != 4 || Period_Out !== 20'd16 || Vpp_Out !== 8'd240) begin
            errors++; $display("FAIL saw_final: got n=%0d P=%0d vpp=%0d want n=4 P=16 vpp=240", nvalid, Period_Out, Vpp_Out);
        end
    endtask

    task automatic test_noise();
        int nvalid = 0;
        do_reset();
        cycle(1'b1, 8'd100);
        for (int k = 0; k < 30; k++) begin
            cycle(1'b1, (k % 2 == 0) ? 8'd140 : 8'd150);
            if (Meas_Valid === 1'b1) nvalid++;
            vectors++;
            if ({Meas_Valid, No_Signal} !== {e_valid, e_nosig}) begin
                errors++; $display("FAIL noise_flags: got v=%b ns=%b want v=%b ns=%b", Meas_Valid, No_Signal, e_valid, e_nosig);
            end
        end
        cycle(1'b1, 8'd100);
        cycle(1'b1, 8'd150);
        vectors++;
        if (nvalid != 0 || Meas_Valid !== 1'b1 || Period_Out !== 20'd30) begin
            errors++; $display("FAIL noise_single: got chatter=%0d v=%b P=%0d want 0 1 30", nvalid, Meas_Valid, Period_Out);
        end
        vectors++;
        if ({Period_Out, Max_Out, Min_Out, Vpp_Out} !== {e_period, e_max, e_min, e_vpp}) begin
            errors++; $display("FAIL noise_out: got max=%0d min=%0d want max=%0d min=%0d", Max_Out, Min_Out, e_max, e_min);
        end
    endtask

    task automatic test_gated_en();
        int last = -1;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 20; k++) begin
                cycle(1'b1, (k < 10) ? 8'd255 : 8'd0);
                vectors++;
                if ({Meas_Valid, Period_Out, Max_Out, Min_Out, Vpp_Out, No_Signal} !== {e_valid, e_period, e_max, e_min, e_vpp, e_nosig}) begin
                    errors++;
                    $display("FAIL gated_out: got v=%b P=%0d vpp=%0d want v=%b P=%0d vpp=%0d",
                             Meas_Valid, Period_Out, Vpp_Out, e_valid, e_period, e_vpp);
                end
                if (Meas_Valid === 1'b1) begin
                    if (last >= 0) begin
                        vectors++;
                        if (cyc - last != 40) begin
                            errors++; $display("FAIL gated_spacing: got %0d cycles want 40", cyc - last);
                        end
                    end
                    last = cyc;
                end
                cycle(1'b0, 8'($urandom));
                vectors++;
                if ({Meas_Valid, Period_Out, No_Signal} !== {e_valid, e_period, e_nosig}) begin
                    errors++; $display("FAIL gated_hold: got v=%b P=%0d want v=%b P=%0d", Meas_Valid, Period_Out, e_valid, e_period);
                end
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 60; i++) cycle(1'b1, ((i % 20) < 10) ? 8'd255 : 8'd0);
        for (int i = 0; i < 60; i++) begin
            cycle(1'b1, 8'd200);
            vectors++;
            if ({Meas_Valid, Period_Out, Max_Out, Min_Out, Vpp_Out, No_Signal} !== {e_valid, e_period, e_max, e_min, e_vpp, e_nosig}) begin
                errors++;
                $display("FAIL timeout_out: step %0d got v=%b ns=%b P=%0d want v=%b ns=%b P=%0d",
                         i, Meas_Valid, No_Signal, Period_Out, e_valid, e_nosig, e_period);
            end
        end
        vectors++;
        if (No_Signal !== 1'b1 || Period_Out !== 20'd20 || Vpp_Out !== 8'd255) begin
            errors++; $display("FAIL timeout_set: got ns=%b P=%0d vpp=%0d want 1 20 255", No_Signal, Period_Out, Vpp_Out);
        end
        for (int i = 0; i < 60; i++) begin
            cycle(1'b1, ((i % 20) < 10) ? 8'd255 : 8'd0);
            vectors++;
            if ({Meas_Valid, No_Signal} !== {e_valid, e_nosig}) begin
                errors++; $display("FAIL timeout_clear: got v=%b ns=%b want v=%b ns=%b", Meas_Valid, No_Signal, e_valid, e_nosig);
            end
        end
        // Rising event lands exactly where the timeout would fire: event must win.
        cycle(1'b1, 8'd255);
        for (int i = 0; i < 49; i++) cycle(1'b1, 8'd0);
        cycle(1'b1, 8'd255);
        vectors++;
        if (Meas_Valid !== 1'b1 || Period_Out !== 20'd50 || No_Signal !== 1'b0) begin
            errors++; $display("FAIL timeout_priority: got v=%b P=%0d ns=%b want 1 50 0", Meas_Valid, Period_Out, No_Signal);
        end
    endtask

    task automatic test_reset_mid();
        int nvalid = 0;
        do_reset();
        for (int i = 0; i < 65; i++) cycle(1'b1, ((i % 20) < 10) ? 8'd255 : 8'd0);
        Rstn = 1'b0;
        #1;
        vectors++;
        if ({Period_Out, Max_Out, Min_Out, Vpp_Out, Meas_Valid, No_Signal} !== 46'd0) begin
            errors++; $display("FAIL midreset_clear: got P=%0d max=%0d vpp=%0d, want 0", Period_Out, Max_Out, Vpp_Out);
        end
        #2 Rstn = 1'b1;
        model_reset();
        for (int i = 0; i < 60; i++) begin
            cycle(1'b1, ((i % 20) < 10) ? 8'd255 : 8'd0);
            if (Meas_Valid === 1'b1) begin
                nvalid++;
                vectors++;
                if (i != 40) begin
                    errors++; $display("FAIL midreset_first: got pulse at sample %0d want 40", i);
                end
            end
        end
        vectors++;
        if (nvalid != 1 || Period_Out !== 20'd20) begin
            errors++; $display("FAIL midreset_count: got n=%0d P=%0d want 1 20", nvalid, Period_Out);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int seg = 0; seg < 60; seg++) begin
            int mode = $urandom_range(0, 5);
            int len  = $urandom_range(20, 80);
            int hl   = $urandom_range(1, 20);
            int ll   = $urandom_range(1, 20);
            logic [7:0] lvl = 8'($urandom);
            for (int i = 0; i < len; i++) begin
                logic [7:0] d;
                logic en;
                if (mode <= 3)
                    d = ((i % (hl + ll)) < hl) ? 8'($urandom_range(144, 255)) : 8'($urandom_range(0, 112));
                else if (mode == 4)
                    d = 8'($urandom);
                else
                    d = lvl;
                en = ($urandom_range(0, 3) != 0);
                cycle(en, d);
                vectors++;
                if ({Meas_Valid, Period_Out, Max_Out, Min_Out, Vpp_Out, No_Signal} !== {e_valid, e_period, e_max, e_min, e_vpp, e_nosig}) begin
                    errors++;
                    $display("FAIL random_out: cyc %0d got v=%b P=%0d max=%0d min=%0d vpp=%0d ns=%b want v=%b P=%0d max=%0d min=%0d vpp=%0d ns=%b",
                             cyc, Meas_Valid, Period_Out, Max_Out, Min_Out, Vpp_Out, No_Signal,
                             e_valid, e_period, e_max, e_min, e_vpp, e_nosig);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_square();
        test_sawtooth();
        test_noise();
        test_gated_en();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/wave_measure_module.md
WAVE_MEASURE_MODULE -- requirements
Module: wave_measure_module

Interface
REQ-001 Parameter THRESH_HI, 8'd144, rising-crossing upper threshold (unsigned sample code).
REQ-002 Parameter THRESH_LO, 8'd112, re-arm lower threshold; THRESH_LO < THRESH_HI required.
REQ-003 Parameter TIMEOUT, 20'd1000000, accepted samples without a rising crossing before loss-of-signal.
REQ-004 CLK  input  1  single system clock; all logic on rising edge.
REQ-005 Rstn  input  1  asynchronous, active-low reset.
REQ-006 Sample_En  input  1  qualifies Wave_Data; sample accepted on a CLK edge with Sample_En=1.
REQ-007 Wave_Data  input  8  unsigned waveform sample (DDS output format, midscale 128).
REQ-008 Period_Out  output  20  last measured period, in accepted samples.
REQ-009 Max_Out  output  8  maximum sample over last measured period.
REQ-010 Min_Out  output  8  minimum sample over last measured period.
REQ-011 Vpp_Out  output  8  Max_Out - Min_Out.
REQ-012 Meas_Valid  output  1  one-cycle pulse when Period/Max/Min/Vpp update.
REQ-013 No_Signal  output  1  level; set on timeout, cleared by next Meas_Valid.

Function
REQ-014 Hysteresis: armed flag set by accepted sample <= THRESH_LO; rising event = armed and accepted sample >= THRESH_HI, which clears armed in the same cycle.
REQ-015 Armed flag and all counters hold when Sample_En=0; unaccepted samples never affect state.
REQ-016 FSM states: IDLE (no period reference), MEASURE (counting since last rising event).
REQ-017 IDLE: rising event -> MEASURE; sample counter cleared to 0; running max/min loaded with that sample; no Meas_Valid.
REQ-018 MEASURE, accepted non-event sample: counter +1; running max/min updated with sample.
REQ-019 MEASURE, rising event: Period_Out <= counter+1; Max_Out/Min_Out <= running values excluding event sample; Vpp_Out <= their difference; counter <= 0; running max/min reloaded with event sample; state stays MEASURE.
REQ-020 Meas_Valid asserts for exactly one cycle, the cycle after the CLK edge accepting the rising-event sample; outputs updated coincident with it.
REQ-021 Timeout: in MEASURE, accepted non-event sample with counter == TIMEOUT-1 -> No_Signal <= 1, state -> IDLE, armed cleared; measurement outputs hold last values; no Meas_Valid.
REQ-022 Counter is 20-bit and never wraps (TIMEOUT bounds it); Period_Out range 1..TIMEOUT.
REQ-023 Vpp_Out is unsigned 8-bit; Max_Out >= Min_Out always, so no underflow.
REQ-024 Constant input (never crosses both thresholds): no Meas_Valid ever; No_Signal only after entering MEASURE.
REQ-025 Event and timeout on the same sample: event takes priority, no timeout.

Reset
REQ-026 Rstn low asynchronously forces: state IDLE, armed 0, counter 0, Period_Out 0, Max_Out 0, Min_Out 0, Vpp_Out 0, Meas_Valid 0, No_Signal 0.
REQ-027 Reset mid-period discards the partial measurement; first Meas_Valid after release requires two rising events.

Structure
REQ-028 Shared package wave_measure_pkg holds FSM state encoding (IDLE, MEASURE), counter width 20, sample width 8.
REQ-029 Sub-module wave_edge_detect implements REQ-014 (armed flag, rising-event output); remaining logic lives in wave_measure_module.

Verification
REQ-030 Square wave, Sample_En=1, 10 samples 255 then 10 samples 0, repeated -> from second rising edge on, Meas_Valid every 20 cycles, Period_Out=20, Max_Out=255, Min_Out=0, Vpp_Out=255.
REQ-031 Sawtooth 0..255 step 16 (period 16) -> Period_Out=16, Max_Out=240, Min_Out=0, Vpp_Out=240.
REQ-032 Noise at threshold: samples alternating 140/150 after one re-arm at 100 -> exactly one rising event, no chatter.
REQ-033 Square period 20 with Sample_En high every other cycle -> Period_Out=20 samples, Meas_Valid every 40 CLK cycles.
REQ-034 TIMEOUT=50, square input then constant 200 -> No_Signal=1 after 50 accepted samples, outputs hold; square restored -> No_Signal clears on next Meas_Valid.
REQ-035 Rstn pulsed low mid-period -> all outputs 0 immediately; next Meas_Valid only after two rising events.
